uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side byte buffer that sits directly downstream of the UART receiver. Each received byte is captured on the receiver's one-cycle done strobe and stored in a circular FIFO. The buffered bytes are presented to the host through a read-enable / read-valid handshake. The block also reports fill level, a threshold flag and a sticky overflow flag, so the host can drain in bursts without losing characters.

## Interface
Parameters:
- DATA_W, 8, width of one received byte
- DEPTH, 16, number of storage entries; power of two, minimum 2
- ADDR_W, 4, log2(DEPTH); must match DEPTH
- THRESH, 12, fill level at or above which `level_hit` asserts; range 1..DEPTH

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr_data  in  DATA_W  received byte from the UART receiver data output; sampled only when `wr_stb`=1
- wr_stb  in  1  one-cycle byte-done pulse from the UART receiver
- rd_en  in  1  host pop request
- rd_data  out  DATA_W  popped byte; registered; holds its value until the next accepted pop
- rd_valid  out  1  one-cycle pulse; `rd_data` is new this cycle
- empty  out  1  count==0
- full  out  1  count==DEPTH
- count  out  ADDR_W+1  current occupancy, 0..DEPTH
- level_hit  out  1  count>=THRESH
- overflow  out  1  sticky; a byte was dropped
- ovf_clr  in  1  clears `overflow`

## Operation
- Storage: DEPTH x DATA_W register array, with write pointer `wp` and read pointer `rp` of ADDR_W bits each. Pointers wrap naturally from DEPTH-1 to 0. Occupancy is tracked in a separate ADDR_W+1-bit counter; pointers are not compared.
- Write accept: `wr_stb` && (!full || rd_accept). On accept, mem[wp]<=wr_data and wp<=wp+1.
- Read accept (`rd_accept`): `rd_en` && !empty. On accept, rd_data<=mem[rp], rp<=rp+1, and rd_valid<=1 on the next edge. Otherwise rd_valid<=0 and rd_data holds.
- `rd_en` while empty: ignored. No pointer move, no `rd_valid`, no error flag.
- Count update uses the accepted write and read of the same cycle:
  - write only: +1
  - read only: -1
  - both: unchanged
- Simultaneous write and read when full: both accepted, count stays DEPTH, no overflow.
- Simultaneous write and read when empty: the write is accepted and the read is ignored (no bypass). The byte becomes readable from the next cycle.
- Overflow: `wr_stb` && full && !rd_accept drops the byte. Pointers and count are unchanged, and overflow<=1.
- Overflow clear: `ovf_clr` clears the flag. If a new drop occurs in the same cycle as `ovf_clr`, set wins.
- `empty`, `full` and `level_hit` are combinational decodes of the registered `count`.
- Reset state:
  - wp=0, rp=0, count=0, rd_data=0, rd_valid=0, overflow=0
  - therefore empty=1, full=0, level_hit=0
  - Memory contents are not reset.
- Reset mid-operation: all stored bytes are discarded. Any `wr_stb` or `rd_en` sampled in the same cycle as `rst`=1 is ignored.

## Timing
- Write-to-visible latency: a byte written at edge N raises count and clears empty after edge N. `rd_en` at cycle N+1 is therefore accepted.
- Read latency: `rd_en` accepted at edge N gives `rd_data`/`rd_valid` valid in the cycle after edge N (1 cycle).
- Back-to-back `rd_en` pops one byte per cycle, with `rd_valid` high continuously.
- `wr_stb` is assumed never to be high on consecutive cycles at UART rates. Consecutive pulses are still handled, one byte per cycle.
- No combinational path from any input to any output except through `count`; `empty`/`full`/`level_hit` change only after clock edges.

## Test plan
- Reset, then write 0x41, 0x42, 0x43 via three `wr_stb` pulses, then pop three times -> rd_data 0x41, 0x42, 0x43, each with a one-cycle `rd_valid`; count goes 3 to 0; empty=1 at the end.
- Fill 16 bytes 0x00..0x0F -> full=1, count=16, level_hit=1 from the 12th write. A 17th `wr_stb` with 0xAA -> overflow=1, count stays 16. Draining yields 0x00..0x0F with no 0xAA.
- Full FIFO, `wr_stb`(0x55) and `rd_en` in the same cycle -> rd_data=oldest byte, count stays 16, overflow stays 0. 0x55 is read last after 15 further pops.
- Empty FIFO, `wr_stb`(0x7E) and `rd_en` in the same cycle -> no `rd_valid`, count=1. `rd_en` on the next cycle -> rd_data=0x7E.
- Pointer wrap: 40 interleaved write/read pairs with incrementing data -> data order preserved across wrap; count never exceeds 1.
- With overflow=1, assert `ovf_clr` together with a dropping `wr_stb` -> overflow stays 1. `ovf_clr` alone -> 0. Assert `rst` with 5 bytes stored -> count=0, empty=1, rd_valid=0 on the next cycle.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: circular byte buffer behind a UART receiver with level, threshold and sticky overflow flags
module uart_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int THRESH = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_stb,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              level_hit,
  output logic              overflow,
  input  logic              ovf_clr
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wp, rp;
  logic rd_acc, wr_acc, drop;
  always_comb begin
    empty     = count == '0;
    full      = count == (ADDR_W+1)'(DEPTH);
    level_hit = count >= (ADDR_W+1)'(THRESH);
    rd_acc    = rd_en && !empty;
    wr_acc    = wr_stb && (!full || rd_acc);
    drop      = wr_stb && full && !rd_acc;
  end
  always_ff @(posedge clk)
    if (!rst && wr_acc) mem[wp] <= wr_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) begin
        rd_data <= mem[rp];
        rp      <= rp + 1'b1;
      end
      if (wr_acc) wp <= wp + 1'b1;
      count    <= (wr_acc && !rd_acc) ? count + 1'b1 : (rd_acc && !wr_acc) ? count - 1'b1 : count;
      overflow <= drop ? 1'b1 : ovf_clr ? 1'b0 : overflow;
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed stimulus checked against a queue model every cycle plus literal spot checks
module tb_uart_rx_fifo;
  logic       clk = 0, rst = 1, wr_stb = 0, rd_en = 0, ovf_clr = 0;
  logic [7:0] wr_data = 0, rd_data;
  logic       rd_valid, empty, full, level_hit, overflow;
  logic [4:0] count;
  int total = 0, bad = 0;
  logic [7:0] q[$];
  logic [7:0] m_data = 0;
  logic       m_valid = 0, m_ovf = 0, chk = 0;

  uart_rx_fifo #(.DATA_W(8), .DEPTH(16), .ADDR_W(4), .THRESH(12)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_stb(wr_stb), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty), .full(full),
    .count(count), .level_hit(level_hit), .overflow(overflow), .ovf_clr(ovf_clr));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    automatic bit rd = rd_en && q.size() > 0;
    automatic bit was_full = q.size() == 16;
    if (rst) begin
      q.delete();
      m_valid = 0;
      m_data = 0;
      m_ovf = 0;
      chk = 1;
    end else begin
      m_valid = rd;
      if (rd) m_data = q.pop_front();
      if (wr_stb && (!was_full || rd)) q.push_back(wr_data);
      if (wr_stb && was_full && !rd) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
    end
  end

  always @(negedge clk) if (chk) begin
    check("m_rd_valid", rd_valid, m_valid);
    check("m_rd_data", rd_data, m_data);
    check("m_count", count, q.size());
    check("m_empty", empty, q.size() == 0);
    check("m_full", full, q.size() == 16);
    check("m_level_hit", level_hit, q.size() >= 12);
    check("m_overflow", overflow, m_ovf);
  end

  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
    wr_stb = w; wr_data = d; rd_en = r; ovf_clr = c;
    @(posedge clk); #1;
    wr_stb = 0; rd_en = 0; ovf_clr = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_level", level_hit, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_ovf", overflow, 0);
    check("rst_data", rd_data, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 8'h41 + 8'(i), 0, 0);
      cyc(0, 0, 0, 0);
    end
    check("abc_count", count, 3);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 0);
      check("abc_valid", rd_valid, 1);
      check("abc_data", rd_data, 8'h41 + 8'(i));
      check("abc_count_dn", count, 2 - i);
    end
    check("abc_empty", empty, 1);
    cyc(0, 0, 0, 0);
    check("abc_valid_pulse", rd_valid, 0);
    cyc(0, 0, 1, 0);
    check("empty_pop_ignored", rd_valid, 0);
    for (int i = 0; i < 16; i++) begin
      cyc(1, 8'(i), 0, 0);
      check("fill_level", level_hit, i >= 11);
    end
    check("fill_full", full, 1);
    check("fill_count", count, 16);
    cyc(1, 8'hAA, 0, 0);
    check("drop_ovf", overflow, 1);
    check("drop_count", count, 16);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 1, 0);
      check("drain_data", rd_data, i);
    end
    check("drain_empty", empty, 1);
    cyc(0, 0, 0, 1);
    check("clr_ovf", overflow, 0);
    for (int i = 0; i < 16; i++) cyc(1, 8'h20 + 8'(i), 0, 0);
    cyc(1, 8'h55, 1, 0);
    check("fullrw_data", rd_data, 8'h20);
    check("fullrw_count", count, 16);
    check("fullrw_ovf", overflow, 0);
    for (int i = 0; i < 15; i++) cyc(0, 0, 1, 0);
    check("fullrw_pen", rd_data, 8'h2F);
    cyc(0, 0, 1, 0);
    check("fullrw_last", rd_data, 8'h55);
    cyc(1, 8'h7E, 1, 0);
    check("emptyrw_valid", rd_valid, 0);
    check("emptyrw_count", count, 1);
    cyc(0, 0, 1, 0);
    check("emptyrw_data", rd_data, 8'h7E);
    check("emptyrw_v", rd_valid, 1);
    for (int i = 0; i < 40; i++) begin
      cyc(1, 8'h80 + 8'(i), 0, 0);
      check("wrap_count", count, 1);
      cyc(0, 0, 1, 0);
      check("wrap_data", rd_data, 8'h80 + 8'(i));
    end
    for (int i = 0; i < 17; i++) cyc(1, 8'(i), 0, 0);
    check("ovf_set", overflow, 1);
    cyc(1, 8'h99, 0, 1);
    check("ovf_set_wins", overflow, 1);
    cyc(0, 0, 0, 1);
    check("ovf_clr_alone", overflow, 0);
    for (int i = 0; i < 11; i++) cyc(0, 0, 1, 0);
    check("pre_rst_count", count, 5);
    rst = 1;
    cyc(1, 8'hEE, 1, 0);
    rst = 0;
    check("midrst_count", count, 0);
    check("midrst_empty", empty, 1);
    check("midrst_valid", rd_valid, 0);
    cyc(0, 0, 1, 0);
    check("midrst_nopop", rd_valid, 0);
    cyc(0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
